bank_request_arbiter: RTL and testbench

Upstream stage of multi_bank_memory. Accepts memory requests from NUM_CLIENTS clients over valid/ready handshakes and picks one per cycle by round-robin. It drives the memory's we/addr/din/bank_sel from registers and returns read data to the issuing client with a tagged valid pulse. Issue order equals memory order, so read-after-write across clients is coherent without extra logic.

---
 rtl/bank_mem_pkg.sv | 27 ++
 rtl/bank_request_arbiter_rr.sv | 48 ++++
 rtl/bank_request_arbiter.sv | 126 ++++++++++++
 tb/tb_bank_request_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bank_mem_pkg.sv
// Shared types and defaults for the bank request arbiter.
// Used by the arbiter sub-module and the top level.
package bank_mem_pkg;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int ADDR_WIDTH_DEF     = 4;
  localparam int NUM_BANKS_DEF      = 4;
  localparam int BANK_SEL_WIDTH_DEF = 2;
  localparam int NUM_CLIENTS_DEF    = 2;
  localparam int READ_LATENCY_DEF   = 1;
  localparam int MAX_CLIENTS        = 16;

  function automatic int cid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CID_W = cid_width(MAX_CLIENTS);

  typedef logic [CID_W-1:0] cid_t;

  typedef struct packed {
    logic valid;
    cid_t client_id;
    logic err;
  } tag_t;

endpackage

// File: rtl/bank_request_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, scanning upward from a pointer.
// The pointer moves past the winner; it holds when nobody requests.
module rr_arbiter
  import bank_mem_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output cid_t         grant_id,
  output logic         any
);

  cid_t ptr;
  int   tgt;

  // Walk offsets from far to near so the nearest requester wins last.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    tgt      = 0;
    for (int off = N-1; off >= 0; off--) begin
      tgt = int'(ptr) + off;
      if (tgt >= N) tgt = tgt - N;
      for (int c = 0; c < N; c++) begin
        if (rst_n && req[c] && (c == tgt)) begin
          grant    = '0;
          grant[c] = 1'b1;
          grant_id = cid_t'(c);
          any      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any) begin
      if (grant_id == cid_t'(N-1)) ptr <= '0;
      else ptr <= grant_id + cid_t'(1);
    end
  end

endmodule

// File: rtl/bank_request_arbiter.sv
// Multi-client front end for multi_bank_memory: arbitrate, issue,
// and route read data back to the requester with a tag pipeline.
module bank_request_arbiter
  import bank_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int NUM_BANKS      = NUM_BANKS_DEF,
  parameter int BANK_SEL_WIDTH = BANK_SEL_WIDTH_DEF,
  parameter int NUM_CLIENTS    = NUM_CLIENTS_DEF,
  parameter int READ_LATENCY   = READ_LATENCY_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CLIENTS-1:0]              req_valid,
  output logic [NUM_CLIENTS-1:0]              req_ready,
  input  logic [NUM_CLIENTS-1:0]              req_we,
  input  logic [NUM_CLIENTS*BANK_SEL_WIDTH-1:0] req_bank,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_CLIENTS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_err,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_din,
  output logic [BANK_SEL_WIDTH-1:0]           mem_bank_sel,
  input  logic [DATA_WIDTH-1:0]               mem_dout
);

  logic [NUM_CLIENTS-1:0]    grant;
  cid_t                      grant_id;
  logic                      hs;
  logic                      sel_we;
  logic [BANK_SEL_WIDTH-1:0] sel_bank;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]     sel_wdata;
  logic                      bank_ok;
  tag_t                      tag_in;
  tag_t                      tags [READ_LATENCY+1];
  tag_t                      rsp_tag;
  logic [NUM_CLIENTS-1:0]    rsp_hit;

  rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (hs)
  );

  assign req_ready = grant;

  always_comb begin
    sel_we    = 1'b0;
    sel_bank  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      if (grant[c]) begin
        sel_we    = req_we[c];
        sel_bank  = req_bank[c*BANK_SEL_WIDTH +: BANK_SEL_WIDTH];
        sel_addr  = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bank_ok = int'(sel_bank) < NUM_BANKS;

  always_comb begin
    tag_in           = '0;
    tag_in.valid     = hs & ~sel_we;
    tag_in.client_id = grant_id;
    tag_in.err       = ~bank_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_bank_sel <= '0;
    end else begin
      mem_we <= hs & sel_we & bank_ok;
      if (hs) begin
        mem_addr     <= sel_addr;
        mem_din      <= sel_wdata;
        mem_bank_sel <= sel_bank;
      end
    end
  end

  // Tag i lines up with the memory access i cycles after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= READ_LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= tag_in;
      for (int i = 1; i <= READ_LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  assign rsp_tag = tags[READ_LATENCY];

  always_comb begin
    rsp_hit = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      rsp_hit[c] = rsp_tag.valid && (rsp_tag.client_id == cid_t'(c));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rsp_hit;
      rsp_err   <= rsp_tag.valid & rsp_tag.err;
      if (rsp_tag.valid) rsp_rdata <= rsp_tag.err ? '0 : mem_dout;
    end
  end

endmodule

// File: tb/tb_bank_request_arbiter.sv
// Directed bench for bank_request_arbiter with a 3-bank config
// and a one-cycle synchronous memory model.
module tb_bank_request_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_we;
  logic [3:0] req_bank;
  logic [7:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_din;
  logic [1:0] mem_bank_sel;
  logic [7:0] mem_dout;

  logic [7:0] mem [4][16];

  int nvec;
  int nfail;

  bank_request_arbiter #(.NUM_BANKS(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_bank     (req_bank),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_bank_sel (mem_bank_sel),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_bank_sel][mem_addr] <= mem_din;
    mem_dout <= mem[mem_bank_sel][mem_addr];
  end

  typedef struct {
    logic [1:0] v;
    logic [1:0] we;
    logic [1:0] b1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic [1:0] b0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic [1:0] rdy;
    logic       mwe;
    logic [3:0] maddr;
    logic [7:0] mdin;
    logic [1:0] mbank;
    logic [1:0] rv;
    logic [7:0] rd;
    logic       re;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic [1:0] v, input logic [1:0] we,
    input logic [1:0] b1, input logic [3:0] a1, input logic [7:0] d1,
    input logic [1:0] b0, input logic [3:0] a0, input logic [7:0] d0,
    input logic [1:0] rdy, input logic mwe, input logic [3:0] maddr,
    input logic [7:0] mdin, input logic [1:0] mbank,
    input logic [1:0] rv, input logic [7:0] rd, input logic re);
    vec_t t;
    t.v = v; t.we = we;
    t.b1 = b1; t.a1 = a1; t.d1 = d1;
    t.b0 = b0; t.a0 = a0; t.d0 = d0;
    t.rdy = rdy; t.mwe = mwe; t.maddr = maddr;
    t.mdin = mdin; t.mbank = mbank;
    t.rv = rv; t.rd = rd; t.re = re;
    return t;
  endfunction

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    req_valid = t.v;
    req_we    = t.we;
    req_bank  = {t.b1, t.b0};
    req_addr  = {t.a1, t.a0};
    req_wdata = {t.d1, t.d0};
  endtask

  task automatic idle();
    req_valid = 2'b00;
    req_we    = 2'b00;
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) mem[b][a] = 8'h00;
    mem[3][5] = 8'hFF;
    mem[0][6] = 8'hC7;

    // r  v     we    b1 a1 d1     b0 a0 d0     rdy   mwe maddr mdin  mbank rv    rd     re
    tbl[0]  = mk(2'b01,2'b01,2'd0,4'd0,8'h00,2'd0,4'd2,8'hA5,2'b01,1'b1,4'd2,8'hA5,2'd0,2'b00,8'h00,1'b0);
    tbl[1]  = mk(2'b00,2'b00,2'd0,4'd0,8'h00,2'd0,4'd2,8'hA5,2'b00,1'b0,4'd2,8'hA5,2'd0,2'b00,8'h00,1'b0);
    tbl[2]  = mk(2'b01,2'b00,2'd0,4'd0,8'h00,2'd0,4'd2,8'h00,2'b01,1'b0,4'd2,8'h00,2'd0,2'b00,8'h00,1'b0);
    tbl[3]  = mk(2'b10,2'b10,2'd2,4'd4,8'hB3,2'd0,4'd2,8'h00,2'b10,1'b1,4'd4,8'hB3,2'd2,2'b00,8'h00,1'b0);
    tbl[4]  = mk(2'b01,2'b00,2'd2,4'd4,8'hB3,2'd2,4'd4,8'h00,2'b01,1'b0,4'd4,8'h00,2'd2,2'b00,8'h00,1'b0);
    tbl[5]  = mk(2'b10,2'b00,2'd3,4'd5,8'h00,2'd2,4'd4,8'h00,2'b10,1'b0,4'd5,8'h00,2'd3,2'b01,8'hA5,1'b0);
    tbl[6]  = mk(2'b11,2'b11,2'd2,4'd5,8'h7E,2'd1,4'd3,8'h5A,2'b01,1'b1,4'd3,8'h5A,2'd1,2'b00,8'hA5,1'b0);
    tbl[7]  = mk(2'b11,2'b11,2'd2,4'd5,8'h7E,2'd1,4'd3,8'h5A,2'b10,1'b1,4'd5,8'h7E,2'd2,2'b01,8'hB3,1'b0);
    tbl[8]  = mk(2'b11,2'b11,2'd2,4'd5,8'h7E,2'd1,4'd3,8'h5A,2'b01,1'b1,4'd3,8'h5A,2'd1,2'b10,8'h00,1'b1);
    tbl[9]  = mk(2'b11,2'b11,2'd2,4'd5,8'h7E,2'd1,4'd3,8'h5A,2'b10,1'b1,4'd5,8'h7E,2'd2,2'b00,8'h00,1'b0);
    tbl[10] = mk(2'b11,2'b11,2'd2,4'd5,8'h7E,2'd1,4'd3,8'h5A,2'b01,1'b1,4'd3,8'h5A,2'd1,2'b00,8'h00,1'b0);
    tbl[11] = mk(2'b11,2'b11,2'd2,4'd5,8'h7E,2'd1,4'd3,8'h5A,2'b10,1'b1,4'd5,8'h7E,2'd2,2'b00,8'h00,1'b0);
    tbl[12] = mk(2'b10,2'b10,2'd3,4'd7,8'h3C,2'd1,4'd3,8'h5A,2'b10,1'b0,4'd7,8'h3C,2'd3,2'b00,8'h00,1'b0);
    tbl[13] = mk(2'b00,2'b00,2'd3,4'd7,8'h3C,2'd1,4'd3,8'h5A,2'b00,1'b0,4'd7,8'h3C,2'd3,2'b00,8'h00,1'b0);
    tbl[14] = mk(2'b01,2'b00,2'd0,4'd0,8'h00,2'd1,4'd3,8'h00,2'b01,1'b0,4'd3,8'h00,2'd1,2'b00,8'h00,1'b0);
    tbl[15] = mk(2'b10,2'b00,2'd2,4'd5,8'h00,2'd1,4'd3,8'h00,2'b10,1'b0,4'd5,8'h00,2'd2,2'b00,8'h00,1'b0);
    tbl[16] = mk(2'b00,2'b00,2'd2,4'd5,8'h00,2'd1,4'd3,8'h00,2'b00,1'b0,4'd5,8'h00,2'd2,2'b00,8'h00,1'b0);
    tbl[17] = mk(2'b00,2'b00,2'd2,4'd5,8'h00,2'd1,4'd3,8'h00,2'b00,1'b0,4'd5,8'h00,2'd2,2'b01,8'h5A,1'b0);
    tbl[18] = mk(2'b00,2'b00,2'd2,4'd5,8'h00,2'd1,4'd3,8'h00,2'b00,1'b0,4'd5,8'h00,2'd2,2'b10,8'h7E,1'b0);
    tbl[19] = mk(2'b00,2'b00,2'd2,4'd5,8'h00,2'd1,4'd3,8'h00,2'b00,1'b0,4'd5,8'h00,2'd2,2'b00,8'h7E,1'b0);

    // Reset held with both clients requesting.
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_bank  = 4'b0101;
    req_addr  = 8'h9A;
    req_wdata = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 8'(req_ready), 8'h00);
    chk("rst mem_we", 8'(mem_we), 8'h00);
    chk("rst mem_addr", 8'(mem_addr), 8'h00);
    chk("rst mem_din", mem_din, 8'h00);
    chk("rst mem_bank", 8'(mem_bank_sel), 8'h00);
    chk("rst rsp_valid", 8'(rsp_valid), 8'h00);
    chk("rst rsp_rdata", rsp_rdata, 8'h00);
    chk("rst rsp_err", 8'(rsp_err), 8'h00);
    idle();
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    for (int r = 0; r < NV; r++) begin
      drive(tbl[r]);
      @(negedge clk);
      chk($sformatf("r%0d ready", r), 8'(req_ready), 8'(tbl[r].rdy));
      chk($sformatf("r%0d rsp_valid", r), 8'(rsp_valid), 8'(tbl[r].rv));
      chk($sformatf("r%0d rsp_rdata", r), rsp_rdata, tbl[r].rd);
      chk($sformatf("r%0d rsp_err", r), 8'(rsp_err), 8'(tbl[r].re));
      @(posedge clk);
      #1;
      chk($sformatf("r%0d mem_we", r), 8'(mem_we), 8'(tbl[r].mwe));
      chk($sformatf("r%0d mem_addr", r), 8'(mem_addr), 8'(tbl[r].maddr));
      chk($sformatf("r%0d mem_din", r), mem_din, tbl[r].mdin);
      chk($sformatf("r%0d mem_bank", r), 8'(mem_bank_sel), 8'(tbl[r].mbank));
    end
    idle();

    // Read in flight when reset pulses: it must never respond.
    @(posedge clk);
    #1;
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_bank  = 4'b0000;
    req_addr  = 8'h06;
    req_wdata = 16'h0000;
    @(negedge clk);
    chk("mf ready", 8'(req_ready), 8'h01);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b0;
    #1;
    chk("mf rst mem_addr", 8'(mem_addr), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("mf quiet%0d", i), 8'(rsp_valid), 8'h00);
    end

    // Same read after release returns normally.
    @(posedge clk);
    #1;
    req_valid = 2'b01;
    req_addr  = 8'h06;
    @(negedge clk);
    chk("post ready", 8'(req_ready), 8'h01);
    @(posedge clk);
    #1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post rsp_valid", 8'(rsp_valid), 8'h01);
    chk("post rsp_rdata", rsp_rdata, 8'hC7);
    chk("post rsp_err", 8'(rsp_err), 8'h00);
    @(negedge clk);
    chk("post pulse end", 8'(rsp_valid), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
